// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone classic arbiter in front of the
// shared single-port SRAM. M0 is the core data port, M1 the instruction fetch.
// A grant is held for the whole of a master's cycle. A watchdog returns an error
// to a master whose strobe the slave never acks.
//
// Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin contention
// resolution. Without it, M0 always wins contention.
//
// state | meaning
// IDLE  | no grant; slave controls parked low; arbitration happens here
// GNT0  | M0 owns the slave until it drops m0_cyc_i or the watchdog fires
// GNT1  | M1 owns the slave until it drops m1_cyc_i or the watchdog fires

module wb_arbiter2 #(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [31:0]           m0_dat_i,
  output logic [31:0]           m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [31:0]           m1_dat_i,
  output logic [31:0]           m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_dat_o,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   timeout;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // 1 = M1 was granted most recently; reset value lets M0 win the first contention
  logic last_grant_q, last_grant_d;

  // Round-robin history register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // Count cycles the granted strobe waits for ack; an ack in the terminal cycle beats the error
      always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (state_q == IDLE || !s_stb_o || s_ack_i) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          timeout = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Watchdog counter register
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end else begin : g_no_wdog
      assign timeout = 1'b0;
    end
  endgenerate

  // Grant state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Arbitration: grants only leave through IDLE, so handovers always cost one dead cycle
  always_comb begin
    state_d = state_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          if (last_grant_q) begin
            state_d      = GNT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GNT1;
            last_grant_d = 1'b1;
          end
`else
          state_d = GNT0;
`endif
        end else if (m0_cyc_i) begin
          state_d = GNT0;
`ifdef WB_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end else if (m1_cyc_i) begin
          state_d = GNT1;
`ifdef WB_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end
      end
      GNT0: if (timeout || !m0_cyc_i) state_d = IDLE;
      GNT1: if (timeout || !m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux, purely from the registered grant; IDLE parks controls low
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = m0_adr_i;
    s_dat_o = m0_dat_i;
    case (state_q)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state_q == GNT0) && s_ack_i;
  assign m1_ack_o = (state_q == GNT1) && s_ack_i;
  assign m0_err_o = (state_q == GNT0) && timeout;
  assign m1_err_o = (state_q == GNT1) && timeout;

endmodule
